cpu_program_loader_mem: RTL
===========================

Name: cpu_program_loader_mem

Overview:
- Upstream program store for the tiny 6-bit accumulator CPU.
- Serves 64 x 6-bit instruction/data words on the CPU's address/data pins:
  - CPU address output (bits 5:0) drives cpu_addr.
  - cpu_rdata drives the CPU's 6-bit input field (bits 7:2).
- A serial loader FSM writes programs into the store at runtime, replacing the hard-wired bench memory.
- Holds the CPU in reset while a load frame is in progress.

Parameters:
- AW, 6, address width; depth = 2**AW words.
- DW, 6, data word width.
- HOLDOFF, 2, cycles cpu_rst_n stays low after load_en falls.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_en  in  1  load frame active; level, sampled on clk.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial data, MSB first.
- cpu_addr  in  AW  CPU fetch/read address.
- cpu_rdata  out  DW  mem[cpu_addr], combinational read.
- cpu_rst_n  out  1  registered reset to CPU, active-low.
- load_busy  out  1  FSM not IDLE.
- words_written  out  AW+1  data words written this frame; saturates at 2**AW.
- frame_err  out  1  sticky; last frame ended with a partial field.

Behaviour:
- Reset (async, rst_n=0):
  - All mem words = 0; FSM = IDLE.
  - cpu_rst_n = 0, load_busy = 0, words_written = 0, frame_err = 0.
  - Shift register, bit counter, wr_ptr and pending write cleared.
  - A frame interrupted by reset is discarded without error.
  - Release: cpu_rst_n goes 1 on the first clk edge with rst_n=1 and load_en=0.
- Read port:
  - cpu_rdata = mem[cpu_addr], combinational.
  - A written word is visible starting the cycle after the mem-update edge.
- FSM states: IDLE, ADDR, DATA, HOLD.
  - IDLE: load_en=1 -> ADDR; clear words_written, frame_err, bit_cnt.
  - ADDR: each bit_valid shifts bit_in in. After the 6th bit: wr_ptr = assembled address, -> DATA, bit_cnt = 0.
  - DATA: each bit_valid shifts bit_in in. At the edge sampling the 6th bit, wr_pend is set. At the next edge:
    - mem[wr_ptr] <= word;
    - wr_ptr <= wr_ptr + 1, wrapping 63 -> 0;
    - words_written increments, saturating at 64.
  - In ADDR or DATA, load_en=0 -> HOLD.
    - bit_cnt != 0: frame_err <= 1, partial field dropped.
    - A pending write (wr_pend) still completes.
  - HOLD: counts HOLDOFF cycles, then -> IDLE. load_en=1 during HOLD -> ADDR immediately (new frame; counters cleared).
- bit_valid is ignored in IDLE and HOLD.
- A bit_valid in the same cycle load_en falls is ignored.
- load_busy = (state != IDLE), registered with the state.
- cpu_rst_n is a registered output:
  - 0 while state != IDLE or rst_n = 0;
  - 1 otherwise.
  - Goes low one cycle after load_en is first sampled high.
  - Goes high the cycle after HOLD -> IDLE.
- A frame with only an address (6 bits, no data) writes nothing and raises no error.
- More than 64 data words: writes wrap and overwrite; words_written stays at 64.

Test Plan:
- Reset, then read all 64 addresses -> cpu_rdata = 0 everywhere; cpu_rst_n = 1 one cycle after rst_n rises.
- Load frame: addr 5 (000101), data 7 (000111), 63 (111111) -> mem[5]=7, mem[6]=63, words_written=2, frame_err=0. cpu_rst_n is low from load_en rise+1 until 2 cycles after load_en falls, +1.
- Addr 62, data 1, 2, 3 -> mem[62]=1, mem[63]=2, mem[0]=3 (wrap).
- Addr 0, data 4, then 3 more bits before load_en drops -> mem[0]=4 only, words_written=1, frame_err=1. frame_err clears at next frame start.
- Assert rst_n=0 mid-DATA after addr 10 + 3 bits -> all mem=0, FSM IDLE, frame_err=0, cpu_rst_n=0.
- Load the 12-word counter program (1,2,16,6,0,7,63,4,1,3,5,7 at addr 0..11), release, run the CPU -> CPU output strobes appear matching the bench-memory run.

Source files
------------

// File: rtl/cpu_program_loader_mem_if.sv
// Bus bundle between the serial program loader and its environment:
// serial load stream in, CPU read port and loader status out.
interface cpu_program_loader_mem_if #(
  parameter int AW = 6,
  parameter int DW = 6
);
  logic          load_en;
  logic          bit_valid;
  logic          bit_in;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rst_n;
  logic          load_busy;
  logic [AW:0]   words_written;
  logic          frame_err;

  // Environment side: drives the load stream and the fetch address.
  modport master (
    output load_en, bit_valid, bit_in, cpu_addr,
    input  cpu_rdata, cpu_rst_n, load_busy, words_written, frame_err
  );

  // Loader/store side.
  modport slave (
    input  load_en, bit_valid, bit_in, cpu_addr,
    output cpu_rdata, cpu_rst_n, load_busy, words_written, frame_err
  );
endinterface

// File: rtl/cpu_program_loader_mem.sv
// Program store for the 6-bit accumulator CPU. A serial frame carries one
// start address followed by any number of data words (MSB first); words are
// written to consecutive locations. The CPU is held in reset while a frame is
// in progress and for HOLDOFF cycles after it ends.
module cpu_program_loader_mem #(
  parameter int AW      = 6,
  parameter int DW      = 6,
  parameter int HOLDOFF = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cpu_program_loader_mem_if.slave  bus
);
  localparam int DEPTH = 1 << AW;
  localparam int FW    = (AW > DW) ? AW : DW;
  localparam int CW    = $clog2(FW + 1);
  localparam int HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [AW:0] WMAX = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic [FW-1:0]   shift_in_s;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            wr_pend_q, wr_pend_d;
  logic [AW:0]     words_q, words_d;
  logic            frame_err_q, frame_err_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            busy_q;
  logic            cpu_rst_n_q;
  logic            mem_we_s;
  logic [DW-1:0]   mem_q [DEPTH];

  // Next-state logic: bit assembly, frame sequencing and write bookkeeping.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    wr_pend_d   = 1'b0;
    words_d     = words_q;
    frame_err_d = frame_err_q;
    hold_cnt_d  = hold_cnt_q;
    mem_we_s    = 1'b0;
    shift_in_s  = {shift_q[FW-2:0], bus.bit_in};

    // A completed data word is committed one edge after its last bit,
    // whatever the FSM does on that same edge.
    if (wr_pend_q) begin
      mem_we_s = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (words_q != WMAX) begin
        words_d = words_q + 1'b1;
      end else begin
        words_d = words_q;
      end
    end else begin
      mem_we_s = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.load_en) begin
          state_d     = ST_ADDR;
          words_d     = '0;
          frame_err_d = 1'b0;
          bit_cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (!bus.load_en) begin
          // Frame ends; any partially received field is dropped.
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          bit_cnt_d  = '0;
          if (bit_cnt_q != '0) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = frame_err_q;
          end
        end else if (bus.bit_valid) begin
          shift_d = shift_in_s;
          if ((state_q == ST_ADDR) && (bit_cnt_q == CW'(AW - 1))) begin
            bit_cnt_d = '0;
            wr_ptr_d  = shift_in_s[AW-1:0];
            state_d   = ST_DATA;
          end else if ((state_q == ST_DATA) && (bit_cnt_q == CW'(DW - 1))) begin
            bit_cnt_d = '0;
            wr_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (bus.load_en) begin
          state_d     = ST_ADDR;
          words_d     = '0;
          frame_err_d = 1'b0;
          bit_cnt_d   = '0;
        end else if (hold_cnt_q == HW'(HOLDOFF - 1)) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader state and status registers, including the registered CPU reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      wr_pend_q   <= 1'b0;
      words_q     <= '0;
      frame_err_q <= 1'b0;
      hold_cnt_q  <= '0;
      busy_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_pend_q   <= wr_pend_d;
      words_q     <= words_d;
      frame_err_q <= frame_err_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_q      <= (state_d != ST_IDLE);
      cpu_rst_n_q <= (state_q == ST_IDLE);
    end
  end

  // Word store: cleared by reset, written from the assembled data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_q[wr_ptr_q] <= shift_q[DW-1:0];
    end
  end

  assign bus.cpu_rdata     = mem_q[bus.cpu_addr];
  assign bus.cpu_rst_n     = cpu_rst_n_q;
  assign bus.load_busy     = busy_q;
  assign bus.words_written = words_q;
  assign bus.frame_err     = frame_err_q;
endmodule
